// File: rtl/cpu_mon_pkg.sv
// Shared types for the CPU event monitor.
// FSM state encoding and the read-select index of the cycle counter.
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_t;

  localparam int MON_N_EVT = 4;
  localparam int SEL_CYC   = MON_N_EVT;

  // The cycle counter always sits one past the last event channel.
  function automatic int sel_cyc(input int n_evt);
    return n_evt;
  endfunction

endpackage

// File: rtl/mon_sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// Clears on reset or on a synchronous clear.
module mon_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (inc_i) begin
      if (cnt_o == '1) begin
        ovf_o <= 1'b1;
      end else begin
        cnt_o <= cnt_o + W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_event_monitor.sv
// Performance monitor: cycle budget FSM, per-channel
// saturating event counters and a registered read port.
module cpu_event_monitor
  import cpu_mon_pkg::*;
#(
  parameter int N_EVT = 4,
  parameter int CNT_W = 32,
  parameter int LIM_W = 16,
  parameter int SEL_W = $clog2(N_EVT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [LIM_W-1:0] limit_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic [N_EVT-1:0] evt_mask_i,
  input  logic             rd_req_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic             rd_vld_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [N_EVT:0]   ovf_o,
  output logic             running_o,
  output logic             halt_o
);

  localparam int NCNT   = N_EVT + 1;
  localparam int CYC    = sel_cyc(N_EVT);
  localparam int MAX_W  = (CNT_W > LIM_W) ? CNT_W : LIM_W;
  localparam int CMP_W  = MAX_W + 1;

  mon_state_t       state_q;
  logic [LIM_W-1:0] lim_q;
  logic             run;
  logic             hit;
  logic [NCNT-1:0]  inc;
  logic [NCNT-1:0]  ovf;
  logic [CNT_W-1:0] cnt  [NCNT];
  logic [CNT_W-1:0] peek [NCNT];
  logic [CNT_W-1:0] rd_mux;
  logic [CMP_W-1:0] cyc_nxt;

  assign run = (state_q == RUN);
  assign inc = {run, evt_i & evt_mask_i & {N_EVT{run}}};

  for (genvar k = 0; k < NCNT; k++) begin : g_cnt
    mon_sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (inc[k]),
      .cnt_o (cnt[k]),
      .ovf_o (ovf[k])
    );

    // Value the counter holds after this edge, ignoring clear.
    assign peek[k] = (inc[k] && (cnt[k] != '1))
                   ? cnt[k] + CNT_W'(1)
                   : cnt[k];
  end

  assign cyc_nxt = CMP_W'(cnt[CYC]) + CMP_W'(1);
  assign hit     = (lim_q != '0) &&
                   (cyc_nxt == CMP_W'(lim_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lim_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            lim_q   <= limit_i;
          end
        end
        RUN: begin
          if (hit) state_q <= DONE;
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux = peek[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_vld_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_mux;
    end
  end

  assign ovf_o     = ovf;
  assign running_o = (state_q == RUN);
  assign halt_o    = (state_q == DONE);

endmodule

// File: doc/cpu_event_monitor.md
# cpu_event_monitor

Synthesisable performance monitor for the pipelined CPU, sitting beside the core in the top level and fed by single-bit hazard/pipeline event strobes (stall, flush, retire, memory access, …). It counts run cycles and per-channel events in saturating counters, and stops itself after a programmable cycle budget by raising a halt request. It exposes every counter through a registered read port, so a bench or debug host can read stall/flush statistics without probing core internals.

## Interface
- `N_EVT`, 4: number of event channels.
- `CNT_W`, 32: width of each event counter and the cycle counter.
- `LIM_W`, 16: width of the cycle-budget input.
- `SEL_W`, `$clog2(N_EVT+1)`: read-select width (derived; do not override).

- `clk_i` input 1: single clock; all logic is on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: level; begins counting from IDLE.
- `clear_i` input 1: pulse; zeroes counters and overflow flags and returns to IDLE.
- `limit_i` input LIM_W: cycle budget, sampled on the IDLE→RUN transition; 0 = unlimited.
- `evt_i` input N_EVT: event strobes; one count per asserted bit per RUN cycle.
- `evt_mask_i` input N_EVT: 1 = channel enabled; sampled every cycle.
- `rd_req_i` input 1: read request.
- `rd_sel_i` input SEL_W: 0..N_EVT-1 selects an event counter; N_EVT selects the cycle counter.
- `rd_vld_o` output 1: one-cycle pulse, read data valid.
- `rd_data_o` output CNT_W: read data.
- `ovf_o` output N_EVT+1: sticky saturation flags; bit N_EVT is the cycle counter.
- `running_o` output 1: state == RUN.
- `halt_o` output 1: state == DONE; a stop request to the bench or system.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN when `start_i`=1. `limit_i` is latched into `lim_q` on the same edge.
  - RUN→DONE on the edge where the cycle counter reaches `lim_q`, when `lim_q`≠0.
  - DONE is held until `clear_i` or `rst_i`.
  - `clear_i` in any state → IDLE with counters zeroed.
  - Dropping `start_i` during RUN has no effect.
- Counting happens only in RUN. Per cycle:
  - The cycle counter increments by 1.
  - Event counter k increments by 1 when `evt_i[k] & evt_mask_i[k]`.
  - In IDLE and DONE all counters are frozen.
- Saturation: a counter at all-ones stays at all-ones, and its `ovf_o` bit sets on the increment attempt. Flags clear only on `clear_i` or `rst_i`.
- Read port:
  - `rd_req_i`=1 in cycle t gives `rd_vld_o`=1 and `rd_data_o` in cycle t+1, with the value of the selected counter as registered at the end of cycle t (an increment in cycle t is included).
  - `rd_sel_i` > N_EVT returns 0 with `rd_vld_o`=1.
  - Reads are allowed in every state and do not disturb counting. Back-to-back requests are accepted every cycle.
  - `rd_data_o` holds its last value while `rd_vld_o`=0.
- Simultaneous events:
  - `clear_i` and `start_i` together: clear wins and the block stays IDLE. `start_i` is honoured on the next cycle if still high.
  - `clear_i` and `rd_req_i` together: the read returns the pre-clear value.
  - Event on the final RUN cycle: counted.
- `rst_i` mid-operation: identical to `clear_i`, and it also drops any pending `rd_vld_o`.

## Timing
- Reset values:
  - state IDLE; all counters 0; `lim_q`=0.
  - `ovf_o`=0, `rd_vld_o`=0, `rd_data_o`=0.
  - `running_o`=0, `halt_o`=0.
- With budget L≠0: exactly L RUN cycles are counted. `halt_o` rises on the edge that completes cycle L and the cycle counter reads L.
- Read latency is 1 cycle and throughput is 1 read/cycle.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- `cpu_mon_pkg` holds:
  - the `mon_state_t` enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the localparam encoding of the cycle-counter select index, `SEL_CYC = N_EVT`.
- Sub-module `mon_sat_counter`, parametrised by width, with ports:
  - inputs `clk_i`, `rst_i`, `clr_i`, `inc_i`;
  - outputs `cnt_o`, `ovf_o`.
- Instantiate it N_EVT+1 times. The top holds the FSM, `lim_q`, and the read mux/register.

## Test plan
- Reset, start with `limit_i`=30, `evt_i`=0 → `halt_o` rises after exactly 30 RUN cycles; cycle read (sel=4) returns 30; event reads return 0.
- `limit_i`=10, `evt_i[0]` high every cycle and `evt_i[1]` high on alternate cycles, mask=4'b1111 → reads return 10 and 5. With mask bit 1 cleared instead, sel 1 returns 0.
- CNT_W=4, `limit_i`=0, `evt_i[2]` constant for 20 cycles → counter 2 sits at 15 and `ovf_o[2]`=1; `clear_i` → counter 0, flag 0, state IDLE.
- `clear_i` and `start_i` asserted together, then `start_i` held → IDLE for one cycle, then RUN; `lim_q` is taken from the second cycle.
- Read in DONE, then sel=7 with N_EVT=4 → correct frozen value with 1-cycle latency; out-of-range select returns 0 with `rd_vld_o`=1.
- `rst_i` asserted mid-RUN together with `rd_req_i` → next cycle all outputs are at reset values, `rd_vld_o`=0, state IDLE.
